// File: rtl/ram_rr_arbiter_mux.sv
// Round-robin arbiter and mux that lets NUM_PORTS requesters share one single-port RAM.
// The RAM command is registered, and read data is steered back to the issuing port after RdLatency cycles.
module ram_rr_arbiter_mux #(
    parameter int NUM_PORTS = 6,
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8,
    parameter int RdLatency = 1,
    parameter int IdWidth   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           active_i,
    input  logic [NUM_PORTS-1:0]           req_i,
    input  logic [NUM_PORTS-1:0]           lock_i,
    input  logic [NUM_PORTS*AddrWidth-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]           we_i,
    input  logic [NUM_PORTS*DataWidth-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]           gnt_o,
    output logic [NUM_PORTS-1:0]           rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           ram_en_o,
    output logic                           ram_we_o,
    output logic [AddrWidth-1:0]           ram_addr_o,
    output logic [DataWidth-1:0]           ram_wdata_o,
    input  logic [DataWidth-1:0]           ram_rdata_i
);

    logic [IdWidth-1:0] ptr_q, ptr_d;
    logic [IdWidth-1:0] lock_id_q;
    logic               lock_vld_q, lock_vld_d;
    logic               gnt_any;
    logic [IdWidth-1:0] gnt_id;

    // Stage 0 of the read-tracking pipe lines up with ram_en_o; stage RdLatency lines up with ram_rdata_i.
    logic [RdLatency:0]              vld_pipe;
    logic [RdLatency:0][IdWidth-1:0] id_pipe;

    function automatic int wrap(input int v);
        return (v >= NUM_PORTS) ? v - NUM_PORTS : v;
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (!reset_i && active_i) begin
            if (lock_vld_q && req_i[lock_id_q]) begin
                gnt_any = 1'b1;
                gnt_id  = lock_id_q;
            end else begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!gnt_any && req_i[wrap(int'(ptr_q) + i)]) begin
                        gnt_any = 1'b1;
                        gnt_id  = IdWidth'(wrap(int'(ptr_q) + i));
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt_o[i]    = gnt_any && (int'(gnt_id) == i);
            rvalid_o[i] = vld_pipe[RdLatency] && (int'(id_pipe[RdLatency]) == i);
        end
        rdata_o = vld_pipe[RdLatency] ? ram_rdata_i : '0;
    end

    // The wrap is an explicit compare, so the pointer cannot overflow for non-power-of-two port counts.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any)
            ptr_d = (int'(gnt_id) == NUM_PORTS - 1) ? '0 : gnt_id + 1'b1;
        lock_vld_d = gnt_any && lock_i[gnt_id];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            lock_vld_q  <= 1'b0;
            lock_id_q   <= '0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= gnt_id;
            ram_en_o   <= gnt_any;
            ram_we_o   <= gnt_any && we_i[gnt_id];
            if (gnt_any) begin
                ram_addr_o  <= addr_i[AddrWidth*gnt_id +: AddrWidth];
                ram_wdata_o <= wdata_i[DataWidth*gnt_id +: DataWidth];
            end
            vld_pipe <= {vld_pipe[RdLatency-1:0], gnt_any && !we_i[gnt_id]};
            id_pipe  <= {id_pipe[RdLatency-1:0], gnt_id};
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter_mux.sv
// Random plus directed bench for ram_rr_arbiter_mux: read latency 1 and read latency 3 instances share one stimulus.
// A queue-free cycle model gives the expected grant, RAM command and read return.
module tb_ram_rr_arbiter_mux;

    localparam int NP = 6;
    localparam int LAT [2] = '{1, 3};

    logic              clk = 1'b0;
    logic              rst, act;
    logic [NP-1:0]     req, lock, we;
    logic [NP*8-1:0]   addr_p, wdata_p;

    logic [NP-1:0]     gnt_w    [2];
    logic [NP-1:0]     rvalid_w [2];
    logic [7:0]        rdata_w  [2];
    logic              en_w     [2];
    logic              rwe_w    [2];
    logic [7:0]        raddr_w  [2];
    logic [7:0]        rwd_w    [2];
    logic [7:0]        rrd_w    [2];

    always #5 clk = ~clk;

    ram_rr_arbiter_mux #(.NUM_PORTS(NP), .DataWidth(8), .AddrWidth(8), .RdLatency(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .active_i(act), .req_i(req), .lock_i(lock),
        .addr_i(addr_p), .we_i(we), .wdata_i(wdata_p), .gnt_o(gnt_w[0]),
        .rvalid_o(rvalid_w[0]), .rdata_o(rdata_w[0]), .ram_en_o(en_w[0]),
        .ram_we_o(rwe_w[0]), .ram_addr_o(raddr_w[0]), .ram_wdata_o(rwd_w[0]),
        .ram_rdata_i(rrd_w[0]));

    ram_rr_arbiter_mux #(.NUM_PORTS(NP), .DataWidth(8), .AddrWidth(8), .RdLatency(3)) u_dut3 (
        .clk_i(clk), .reset_i(rst), .active_i(act), .req_i(req), .lock_i(lock),
        .addr_i(addr_p), .we_i(we), .wdata_i(wdata_p), .gnt_o(gnt_w[1]),
        .rvalid_o(rvalid_w[1]), .rdata_o(rdata_w[1]), .ram_en_o(en_w[1]),
        .ram_we_o(rwe_w[1]), .ram_addr_o(raddr_w[1]), .ram_wdata_o(rwd_w[1]),
        .ram_rdata_i(rrd_w[1]));

    // One RAM per DUT; unwritten words read back as addr^0x76, so 0x2A holds 0x5C.
    bit [7:0] mem     [2][256];
    bit       written [2][256];
    bit [7:0] rdp     [2][4];

    function automatic bit [7:0] memrd(input int d, input logic [7:0] a);
        return written[d][a] ? mem[d][a] : (a ^ 8'h76);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en_w[d] && rwe_w[d]) begin
                mem[d][raddr_w[d]]     <= rwd_w[d];
                written[d][raddr_w[d]] <= 1'b1;
            end
            rdp[d][0] <= (en_w[d] && !rwe_w[d]) ? memrd(d, raddr_w[d]) : 8'hEE;
            for (int k = 1; k < 4; k++) rdp[d][k] <= rdp[d][k-1];
        end
    end
    assign rrd_w[0] = rdp[0][0];
    assign rrd_w[1] = rdp[1][2];

    // Reference model state
    int       ptr, owner, cnum;
    bit [7:0] refmem [256];
    bit       m_en, m_we;
    bit [7:0] m_addr, m_wd;
    bit       rv_v [2][8];
    int       rv_p [2][8];
    bit [7:0] rv_d [2][8];

    logic [NP-1:0]   st_we;
    logic [NP*8-1:0] st_addr, st_wd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cnum, got, exp);
        end
    endtask

    function automatic int exp_gnt();
        if (rst || !act) return -1;
        if (owner >= 0 && req[owner]) return owner;
        for (int i = 0; i < NP; i++)
            if (req[(ptr + i) % NP]) return (ptr + i) % NP;
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0; owner = -1;
        m_en = 0; m_we = 0; m_addr = 0; m_wd = 0;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 8; s++) rv_v[d][s] = 0;
    endtask

    task automatic set_port(input int k, input logic w, input logic [7:0] a, input logic [7:0] dat);
        st_we[k]        = w;
        st_addr[8*k+:8] = a;
        st_wd[8*k+:8]   = dat;
    endtask

    task automatic run(input bit r, input bit ac, input logic [NP-1:0] rq, input logic [NP-1:0] lk);
        int g, sl;
        logic [NP-1:0] eg, erv;
        logic [7:0] erd;
        @(posedge clk);
        #1;
        rst = r; act = ac; req = rq; lock = lk;
        we = st_we; addr_p = st_addr; wdata_p = st_wd;
        if (r) model_reset();
        #3;
        g  = exp_gnt();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        sl = cnum % 8;
        for (int d = 0; d < 2; d++) begin
            erv = '0;
            erd = 8'h00;
            if (rv_v[d][sl]) begin
                erv[rv_p[d][sl]] = 1'b1;
                erd = rv_d[d][sl];
            end
            rv_v[d][sl] = 0;
            chk("gnt",       32'(gnt_w[d]),    32'(eg));
            chk("ram_en",    32'(en_w[d]),     32'(m_en));
            chk("ram_we",    32'(rwe_w[d]),    32'(m_we));
            chk("ram_addr",  32'(raddr_w[d]),  32'(m_addr));
            chk("ram_wdata", 32'(rwd_w[d]),    32'(m_wd));
            chk("rvalid",    32'(rvalid_w[d]), 32'(erv));
            chk("rdata",     32'(rdata_w[d]),  32'(erd));
        end
        if (!r) begin
            if (g >= 0) begin
                ptr    = (g + 1) % NP;
                owner  = lock[g] ? g : -1;
                m_en   = 1;
                m_we   = we[g];
                m_addr = addr_p[8*g+:8];
                m_wd   = wdata_p[8*g+:8];
                if (we[g]) refmem[m_addr] = m_wd;
                else
                    for (int d = 0; d < 2; d++) begin
                        rv_v[d][(cnum + 1 + LAT[d]) % 8] = 1;
                        rv_p[d][(cnum + 1 + LAT[d]) % 8] = g;
                        rv_d[d][(cnum + 1 + LAT[d]) % 8] = refmem[m_addr];
                    end
            end else begin
                owner = -1;
                m_en  = 0;
                m_we  = 0;
            end
        end
        cnum++;
    endtask

    initial begin
        rst = 1; act = 0; req = '0; lock = '0; we = '0; addr_p = '0; wdata_p = '0;
        st_we = '0; st_addr = '0; st_wd = '0;
        cnum = 0;
        for (int a = 0; a < 256; a++) refmem[a] = 8'(a) ^ 8'h76;
        model_reset();

        run(1, 0, '0, '0);
        run(1, 1, 6'h3F, '0);

        // all ports request continuously: rotation 0..5
        for (int k = 0; k < NP; k++) set_port(k, 1'b0, 8'(8'h40 + k), 8'h00);
        for (int c = 0; c < 12; c++) run(0, 1, 6'h3F, '0);
        for (int c = 0; c < 4; c++) run(0, 1, '0, '0);

        // single read from port 3
        set_port(3, 1'b0, 8'h2A, 8'h00);
        run(0, 1, 6'b001000, '0);
        for (int c = 0; c < 4; c++) run(0, 1, '0, '0);

        // port 1 writes, port 4 reads the same word back
        set_port(1, 1'b1, 8'h10, 8'hA5);
        run(0, 1, 6'b000010, '0);
        run(0, 1, '0, '0);
        set_port(4, 1'b0, 8'h10, 8'h00);
        run(0, 1, 6'b010000, '0);
        for (int c = 0; c < 4; c++) run(0, 1, '0, '0);

        // burst lock by port 2 against ports 0 and 5
        set_port(1, 1'b0, 8'h11, 8'h00);
        run(0, 1, 6'b000010, '0);
        for (int c = 0; c < 4; c++) run(0, 1, 6'b100101, 6'b000100);
        run(0, 1, 6'b100001, '0);
        chk("lock_handoff", 32'(gnt_w[0]), 32'(6'b100000));
        for (int c = 0; c < 4; c++) run(0, 1, '0, '0);

        // reads from ports 0,1,2 on consecutive cycles
        for (int k = 0; k < 3; k++) set_port(k, 1'b0, 8'(8'h20 + k), 8'h00);
        run(0, 1, 6'b000001, '0);
        run(0, 1, 6'b000010, '0);
        run(0, 1, 6'b000100, '0);
        for (int c = 0; c < 5; c++) run(0, 1, '0, '0);

        // active drops with reads in flight
        run(0, 1, 6'h3F, '0);
        run(0, 0, 6'h3F, 6'h3F);
        run(0, 0, 6'h3F, '0);
        for (int c = 0; c < 4; c++) run(0, 1, '0, '0);

        // reset one cycle after a read grant
        set_port(3, 1'b0, 8'h2A, 8'h00);
        run(0, 1, 6'b001000, '0);
        run(1, 1, '0, '0);
        run(0, 1, 6'b010100, '0);
        chk("post_reset_gnt", 32'(gnt_w[1]), 32'(6'b000100));
        for (int c = 0; c < 5; c++) run(0, 1, '0, '0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NP; k++)
                set_port(k, 1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)), 8'($urandom));
            run(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                NP'($urandom), NP'($urandom) & NP'($urandom));
        end
        for (int c = 0; c < 5; c++) run(0, 1, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
